// File: rtl/dds_config_uart_tx.sv
// -----------------------------------------------------------------------------
// dds_config_uart_tx
//
// Serializes one DDS configuration record into the 7-byte, 8N1 frame expected
// by the DDS generator's UART control unit. Byte order on the wire:
//   signal_type, m_word[15:8], m_word[7:0], offset[15:8], offset[7:0],
//   amplitude[15:8], amplitude[7:0]
// Each byte is a start bit (0), 8 data bits LSB first and a stop bit (1).
// GAP_BITS idle bit times separate consecutive bytes of one record. No gap
// follows the last byte.
//
// Parameters
//   CLKS_PER_BIT  sysclk cycles per UART bit (2..65535)
//   GAP_BITS      idle bit times between bytes of a record (0 allowed)
//
// Ports
//   sysclk       in   system clock, all state on the rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   send request, sampled only while busy = 0
//   signal_type  in   byte 0 of the record
//   m_word       in   phase increment M
//   offset       in   DC offset code
//   amplitude    in   amplitude code
//   tx           out  serial line, idle high, registered
//   busy         out  high from acceptance until the record completes
//   done         out  one-cycle pulse in the cycle after the last stop bit
// -----------------------------------------------------------------------------
module dds_config_uart_tx #(
   parameter int CLKS_PER_BIT = 6510,
   parameter int GAP_BITS     = 1
) (
   input  logic        sysclk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  signal_type,
   input  logic [15:0] m_word,
   input  logic [15:0] offset,
   input  logic [15:0] amplitude,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      GAP
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   // With GAP_BITS = 0 the GAP state is never entered, so the value is unused.
   localparam logic [15:0] GAP_LAST  = (GAP_BITS > 0) ? 16'(GAP_BITS - 1) : 16'd0;
   localparam logic [2:0]  LAST_BYTE = 3'd6;
   localparam logic [2:0]  LAST_BIT  = 3'd7;

   state_t      state,    state_nxt;
   logic [15:0] baud_cnt, baud_nxt;
   logic [2:0]  bit_idx,  bit_nxt;
   logic [15:0] gap_cnt,  gap_nxt;
   logic [2:0]  byte_idx, byte_nxt;
   // Latched record; the byte on the wire is always the top byte, and the
   // register shifts left by one byte after each stop bit.
   logic [55:0] record,   record_nxt;
   logic        tx_q,     tx_nxt;
   logic        done_q,   done_nxt;

   logic        bit_end;
   logic [7:0]  cur_byte;
   logic [2:0]  next_bit;

   assign bit_end  = (baud_cnt == BAUD_LAST);
   assign cur_byte = record[55:48];
   assign next_bit = bit_idx + 3'd1;

   // State register. tx is registered so the line never glitches, and the
   // asynchronous reset drives it high immediately to abandon a partial byte.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         gap_cnt  <= '0;
         byte_idx <= '0;
         record   <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed by the next-state logic.
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         gap_cnt  <= gap_nxt;
         byte_idx <= byte_nxt;
         record   <= record_nxt;
         tx_q     <= tx_nxt;
         done_q   <= done_nxt;
      end
   end

   // Next-state and next-output logic. tx_nxt is the line level for the
   // cycle after this edge, so each transition sets the level of the bit it
   // enters.
   always_comb begin
      // NOTE: every output of this block is defaulted first; without that a
      // path that skips an assignment would infer a latch.
      state_nxt  = state;
      baud_nxt   = baud_cnt;
      bit_nxt    = bit_idx;
      gap_nxt    = gap_cnt;
      byte_nxt   = byte_idx;
      record_nxt = record;
      tx_nxt     = tx_q;
      done_nxt   = 1'b0;

      // Free-running bit timer in every active state, restarted at each bit
      // boundary.
      if (state != IDLE) begin
         baud_nxt = bit_end ? 16'd0 : baud_cnt + 16'd1;
      end

      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (start) begin
               record_nxt = {signal_type, m_word, offset, amplitude};
               state_nxt  = START;
               baud_nxt   = '0;
               bit_nxt    = '0;
               gap_nxt    = '0;
               byte_nxt   = '0;
               tx_nxt     = 1'b0;
            end
         end

         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               bit_nxt   = '0;
               tx_nxt    = cur_byte[0];
            end
         end

         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_BIT) begin
                  state_nxt = STOP;
                  bit_nxt   = '0;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_nxt = next_bit;
                  tx_nxt  = cur_byte[next_bit];
               end
            end
         end

         STOP: begin
            if (bit_end) begin
               if (byte_idx == LAST_BYTE) begin
                  state_nxt = IDLE;
                  byte_nxt  = '0;
                  done_nxt  = 1'b1;
                  tx_nxt    = 1'b1;
               end else begin
                  byte_nxt   = byte_idx + 3'd1;
                  record_nxt = {record[47:0], 8'h00};
                  if (GAP_BITS > 0) begin
                     state_nxt = GAP;
                     gap_nxt   = '0;
                     tx_nxt    = 1'b1;
                  end else begin
                     state_nxt = START;
                     tx_nxt    = 1'b0;
                  end
               end
            end
         end

         GAP: begin
            if (bit_end) begin
               if (gap_cnt == GAP_LAST) begin
                  state_nxt = START;
                  gap_nxt   = '0;
                  tx_nxt    = 1'b0;
               end else begin
                  gap_nxt = gap_cnt + 16'd1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

   assign tx   = tx_q;
   assign done = done_q;
   // busy drops in the completion cycle because the FSM is already back in
   // IDLE there, which is also what lets a start in that cycle be accepted.
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_dds_config_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_dds_config_uart_tx
//
// Bench for dds_config_uart_tx. Two instances share clock, reset and record
// inputs: one with GAP_BITS = 1 and one with GAP_BITS = 0, both with
// CLKS_PER_BIT = 16. Expected line waveforms are built from the record bytes
// (start bit, 8 data bits LSB first, stop bit, optional gap bits), and a
// mid-bit sampling UART decoder recovers the bytes from the captured line.
// -----------------------------------------------------------------------------
module tb_dds_config_uart_tx;

   localparam int C = 16;

   typedef struct {
      logic [7:0]  typ;
      logic [15:0] m;
      logic [15:0] off;
      logic [15:0] amp;
      logic [55:0] exp;
      int          poke_at;
   } vec_t;

   logic        sysclk  = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_g1 = 1'b0;
   logic        start_g0 = 1'b0;
   logic [7:0]  signal_type = '0;
   logic [15:0] m_word = '0;
   logic [15:0] offset = '0;
   logic [15:0] amplitude = '0;
   logic        tx_g1, busy_g1, done_g1;
   logic        tx_g0, busy_g0, done_g0;
   logic        use_g0 = 1'b0;
   logic        mon_tx, mon_busy, mon_done;

   int n_checks = 0;
   int n_errors = 0;
   vec_t tbl [6];

   always #5 sysclk = ~sysclk;

   dds_config_uart_tx #(.CLKS_PER_BIT(C), .GAP_BITS(1)) u_dut_g1 (
      .sysclk(sysclk), .reset_n(reset_n), .start(start_g1),
      .signal_type(signal_type), .m_word(m_word), .offset(offset),
      .amplitude(amplitude), .tx(tx_g1), .busy(busy_g1), .done(done_g1)
   );

   dds_config_uart_tx #(.CLKS_PER_BIT(C), .GAP_BITS(0)) u_dut_g0 (
      .sysclk(sysclk), .reset_n(reset_n), .start(start_g0),
      .signal_type(signal_type), .m_word(m_word), .offset(offset),
      .amplitude(amplitude), .tx(tx_g0), .busy(busy_g0), .done(done_g0)
   );

   assign mon_tx   = use_g0 ? tx_g0   : tx_g1;
   assign mon_busy = use_g0 ? busy_g0 : busy_g1;
   assign mon_done = use_g0 ? done_g0 : done_g1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [55:0] model_bytes(input logic [7:0] typ, input logic [15:0] m,
                                                 input logic [15:0] off, input logic [15:0] amp);
      return {typ, m[15:8], m[7:0], off[15:8], off[7:0], amp[15:8], amp[7:0]};
   endfunction

   // Idle line for a number of cycles: tx high, busy and done low.
   task automatic idle_check(input logic g0, input int cycles, input string name);
      int bad;
      bad = 0;
      use_g0 = g0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge sysclk);
         if (mon_tx !== 1'b1 || mon_busy !== 1'b0 || mon_done !== 1'b0) bad++;
      end
      check(name, bad, 0);
   endtask

   // Entered and left at a negedge. Presents the record with start high for
   // one cycle, captures the line for the full record length, and returns in
   // the completion cycle so a caller can chain a back-to-back start.
   task automatic run_record(input logic g0, input vec_t v, input string name);
      int gap, len, bad_wave, first_bad, bad_ctl, nb, idx, p;
      logic [55:0] dec;
      logic [7:0]  b8, cur;
      logic        wave [$];
      logic        got  [$];

      gap = g0 ? 0 : 1;
      len = (70 + 6 * gap) * C;
      for (int by = 0; by < 7; by++) begin
         cur = v.exp[55 - 8 * by -: 8];
         repeat (C) wave.push_back(1'b0);
         for (int b = 0; b < 8; b++) repeat (C) wave.push_back(cur[b]);
         repeat (C) wave.push_back(1'b1);
         if (by < 6) repeat (gap * C) wave.push_back(1'b1);
      end

      use_g0      = g0;
      signal_type = v.typ;
      m_word      = v.m;
      offset      = v.off;
      amplitude   = v.amp;
      if (g0) start_g0 = 1'b1; else start_g1 = 1'b1;
      @(negedge sysclk);
      start_g0 = 1'b0;
      start_g1 = 1'b0;

      bad_ctl = 0;
      for (int i = 0; i < len; i++) begin
         got.push_back(mon_tx);
         if (mon_busy !== 1'b1 || mon_done !== 1'b0) bad_ctl++;
         if (i == v.poke_at) begin
            signal_type = 8'h02;
            m_word      = ~v.m;
            offset      = 16'h1234;
            amplitude   = 16'h4321;
            if (g0) start_g0 = 1'b1; else start_g1 = 1'b1;
         end
         if (i == v.poke_at + 1) begin
            start_g0 = 1'b0;
            start_g1 = 1'b0;
         end
         @(negedge sysclk);
      end

      check({name, "_done"}, mon_done, 1'b1);
      check({name, "_busy_end"}, mon_busy, 1'b0);
      check({name, "_tx_end"}, mon_tx, 1'b1);
      check({name, "_busy_during"}, bad_ctl, 0);

      bad_wave  = 0;
      first_bad = -1;
      for (int i = 0; i < len; i++) begin
         if (got[i] !== wave[i]) begin
            bad_wave++;
            if (first_bad < 0) first_bad = i;
         end
      end
      if (bad_wave != 0) $display("  %s: first line difference at cycle %0d", name, first_bad);
      check({name, "_wave"}, bad_wave, 0);

      dec = '0;
      nb  = 0;
      idx = 0;
      while (idx < len && nb < 7) begin
         if (got[idx] == 1'b0) begin
            b8 = '0;
            for (int b = 0; b < 8; b++) begin
               p = idx + C / 2 + (b + 1) * C;
               b8[b] = (p < len) ? got[p] : 1'b1;
            end
            dec = {dec[47:0], b8};
            nb++;
            idx += 10 * C;
         end else begin
            idx++;
         end
      end
      check({name, "_nbytes"}, nb, 7);
      check({name, "_bytes"}, dec, v.exp);
   endtask

   initial begin
      logic [31:0] r;

      tbl[0] = '{typ: 8'h01, m: 16'd100, off: 16'd1650, amp: 16'd1000,
                 exp: 56'h01_00_64_06_72_03_E8, poke_at: -1};
      tbl[1] = '{typ: 8'h01, m: 16'd100, off: 16'd1650, amp: 16'd1000,
                 exp: 56'h01_00_64_06_72_03_E8, poke_at: 3 * 11 * C + C + 40};
      tbl[2] = '{typ: 8'h02, m: 16'd100, off: 16'd1650, amp: 16'd1000,
                 exp: 56'h02_00_64_06_72_03_E8, poke_at: -1};
      for (int k = 3; k < 6; k++) begin
         r = $urandom;
         tbl[k].typ = r[7:0];
         tbl[k].m   = r[31:16];
         r = $urandom;
         tbl[k].off = r[15:0];
         tbl[k].amp = r[31:16];
         tbl[k].poke_at = int'($urandom_range(0, 1000));
         tbl[k].exp = model_bytes(tbl[k].typ, tbl[k].m, tbl[k].off, tbl[k].amp);
      end

      // Reset held for 10 cycles, then 100 idle cycles with start low.
      begin
         int bad;
         bad = 0;
         repeat (10) begin
            @(negedge sysclk);
            if (tx_g1 !== 1'b1 || busy_g1 !== 1'b0 || done_g1 !== 1'b0 ||
                tx_g0 !== 1'b1 || busy_g0 !== 1'b0 || done_g0 !== 1'b0) bad++;
         end
         check("reset_hold", bad, 0);
         reset_n = 1'b1;
         bad = 0;
         repeat (100) begin
            @(negedge sysclk);
            if (tx_g1 !== 1'b1 || busy_g1 !== 1'b0 || done_g1 !== 1'b0 ||
                tx_g0 !== 1'b1 || busy_g0 !== 1'b0 || done_g0 !== 1'b0) bad++;
         end
         check("idle_after_reset", bad, 0);
      end

      run_record(1'b0, tbl[0], "nominal");
      idle_check(1'b0, 3 * C, "idle_after_nominal");

      run_record(1'b0, tbl[1], "ignore_busy");
      idle_check(1'b0, 4 * C, "no_second_record");

      // Back-to-back: the second start is presented in the done cycle.
      run_record(1'b1, tbl[0], "b2b_first");
      run_record(1'b1, tbl[2], "b2b_second");
      idle_check(1'b1, 2 * C, "idle_after_b2b");

      // Reset during the data bits of byte 2.
      use_g0      = 1'b0;
      signal_type = tbl[0].typ;
      m_word      = tbl[0].m;
      offset      = tbl[0].off;
      amplitude   = tbl[0].amp;
      start_g1    = 1'b1;
      @(negedge sysclk);
      start_g1 = 1'b0;
      repeat (2 * 11 * C + C + 40) @(negedge sysclk);
      check("busy_before_reset", busy_g1, 1'b1);
      reset_n = 1'b0;
      #1;
      check("async_reset_tx", tx_g1, 1'b1);
      check("async_reset_busy", busy_g1, 1'b0);
      check("async_reset_done", done_g1, 1'b0);
      repeat (3) @(negedge sysclk);
      reset_n = 1'b1;
      @(negedge sysclk);
      run_record(1'b0, tbl[0], "after_reset");
      idle_check(1'b0, C, "idle_after_reset_rec");

      // Randomized records alternating between the two instances.
      for (int k = 3; k < 6; k++) begin
         run_record(1'(k % 2), tbl[k], $sformatf("random%0d", k));
         idle_check(1'(k % 2), 2 * C, $sformatf("random%0d_idle", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
